// File: rtl/hpi_pkg.sv
// rtl/hpi_pkg.sv - shared types and constants for the HPI transaction sequencer
package hpi_pkg;

  typedef enum logic [2:0] {
    HPI_IDLE    = 3'd0,
    HPI_SETUP   = 3'd1,
    HPI_STROBE  = 3'd2,
    HPI_HOLD    = 3'd3,
    HPI_RECOVER = 3'd4
  } hpi_seq_state_t;

  localparam int HPI_SETUP_CYC_DEF   = 1;
  localparam int HPI_STROBE_CYC_DEF  = 4;
  localparam int HPI_HOLD_CYC_DEF    = 1;
  localparam int HPI_RECOVER_CYC_DEF = 2;
  localparam int HPI_RD_LAT_DEF      = 2;

  localparam logic HPI_ASSERT   = 1'b0;
  localparam logic HPI_DEASSERT = 1'b1;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // Phase counter is loaded with N-1 so that a phase of N cycles ends when it reads 0.
  function automatic logic [7:0] hpi_phase_load(input int cycles);
    return 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/hpi_txn_sequencer_timer.sv
// rtl/hpi_txn_sequencer_timer.sv - loadable 8-bit down-counter timing each bus phase
module hpi_phase_timer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       done
);

  logic [7:0] count;

  // Load on phase entry, then count down and park at zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign done = (count == 8'd0);

endmodule

// File: rtl/hpi_txn_sequencer.sv
// rtl/hpi_txn_sequencer.sv - turns single-word requests into timed HPI strobe-bus cycles
module hpi_txn_sequencer
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC   = HPI_SETUP_CYC_DEF,
  parameter int STROBE_CYC  = HPI_STROBE_CYC_DEF,
  parameter int HOLD_CYC    = HPI_HOLD_CYC_DEF,
  parameter int RECOVER_CYC = HPI_RECOVER_CYC_DEF,
  parameter int RD_LAT      = HPI_RD_LAT_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        busy,
  output logic [1:0]  sw_address,
  output logic [15:0] sw_data_out,
  output logic        sw_r,
  output logic        sw_w,
  output logic        sw_cs,
  input  logic [15:0] sw_data_in
);

  hpi_seq_state_t state, state_next;

  logic              ready_q;
  logic              wr_q;
  logic              resp_sent;
  logic              accept;
  logic              strobe_last;
  logic              tmr_load;
  logic [7:0]        tmr_value;
  logic              tmr_done;
  logic [RD_LAT-1:0] cap_pipe;

  logic cs_d, r_d, w_d, busy_d, ready_d;

  // ready_q comes out of reset at 1 so the first cycle after Reset can accept;
  // masking with Reset keeps req_ready low while Reset is applied.
  assign req_ready   = ready_q && !Reset;
  assign accept      = req_valid && req_ready && (state == HPI_IDLE);
  assign strobe_last = (state == HPI_STROBE) && tmr_done;

  hpi_phase_timer u_phase_timer (
    .Clk        (Clk),
    .Reset      (Reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  // State register plus per-transaction bookkeeping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= HPI_IDLE;
      wr_q      <= 1'b0;
      resp_sent <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        wr_q      <= req_write;
        resp_sent <= 1'b0;
      end else if (resp_valid) begin
        resp_sent <= 1'b1;
      end
    end
  end

  // Next-state: walk the phases; RECOVER also waits for the response to go out.
  always_comb begin
    state_next = state;
    case (state)
      HPI_IDLE:    if (accept)   state_next = HPI_SETUP;
      HPI_SETUP:   if (tmr_done) state_next = HPI_STROBE;
      HPI_STROBE:  if (tmr_done) state_next = HPI_HOLD;
      HPI_HOLD:    if (tmr_done) state_next = HPI_RECOVER;
      HPI_RECOVER: if (tmr_done && (resp_valid || resp_sent)) state_next = HPI_IDLE;
      default:     state_next = HPI_IDLE;
    endcase
  end

  // Reload the phase timer whenever a new phase is entered.
  always_comb begin
    tmr_load  = (state_next != state);
    tmr_value = 8'd0;
    case (state_next)
      HPI_SETUP:   tmr_value = hpi_phase_load(SETUP_CYC);
      HPI_STROBE:  tmr_value = hpi_phase_load(STROBE_CYC);
      HPI_HOLD:    tmr_value = hpi_phase_load(HOLD_CYC);
      HPI_RECOVER: tmr_value = hpi_phase_load(RECOVER_CYC);
      default:     tmr_value = 8'd0;
    endcase
  end

  // Output decode from the next state so the registered pins line up with the state.
  always_comb begin
    cs_d    = HPI_DEASSERT;
    r_d     = HPI_DEASSERT;
    w_d     = HPI_DEASSERT;
    busy_d  = (state_next != HPI_IDLE);
    ready_d = (state_next == HPI_IDLE);
    case (state_next)
      HPI_SETUP, HPI_HOLD: cs_d = HPI_ASSERT;
      HPI_STROBE: begin
        cs_d = HPI_ASSERT;
        if (wr_q) w_d = HPI_ASSERT;
        else      r_d = HPI_ASSERT;
      end
      default: cs_d = HPI_DEASSERT;
    endcase
  end

  // Output registers; address/data are loaded at accept and held until the next one.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_cs       <= HPI_DEASSERT;
      sw_r        <= HPI_DEASSERT;
      sw_w        <= HPI_DEASSERT;
      busy        <= 1'b0;
      ready_q     <= 1'b1;
      sw_address  <= HPI_DATA;
      sw_data_out <= 16'd0;
    end else begin
      sw_cs   <= cs_d;
      sw_r    <= r_d;
      sw_w    <= w_d;
      busy    <= busy_d;
      ready_q <= ready_d;
      if (accept) begin
        sw_address <= req_addr;
        if (req_write) sw_data_out <= req_wdata;
      end
    end
  end

  // Capture pipeline: tracks the last strobe cycle through the downstream read latency.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cap_pipe   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 16'd0;
    end else begin
      cap_pipe[0] <= strobe_last;
      for (int i = 1; i < RD_LAT; i++) cap_pipe[i] <= cap_pipe[i-1];
      resp_valid <= cap_pipe[RD_LAT-1];
      if (cap_pipe[RD_LAT-1] && !wr_q) resp_rdata <= sw_data_in;
    end
  end

endmodule

// File: tb/tb_hpi_txn_sequencer.sv
// tb/tb_hpi_txn_sequencer.sv - directed self-checking bench with response scoreboard
module tb_hpi_txn_sequencer;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic        req_valid_a, req_write_a, req_ready_a, resp_valid_a, busy_a;
  logic        sw_r_a, sw_w_a, sw_cs_a;
  logic [1:0]  req_addr_a, sw_address_a;
  logic [15:0] req_wdata_a, resp_rdata_a, sw_data_out_a, sw_data_in_a;

  logic        req_valid_b, req_write_b, req_ready_b, resp_valid_b, busy_b;
  logic        sw_r_b, sw_w_b, sw_cs_b;
  logic [1:0]  req_addr_b, sw_address_b;
  logic [15:0] req_wdata_b, resp_rdata_b, sw_data_out_b, sw_data_in_b;

  hpi_txn_sequencer u_dut_a (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .busy(busy_a),
    .sw_address(sw_address_a), .sw_data_out(sw_data_out_a),
    .sw_r(sw_r_a), .sw_w(sw_w_a), .sw_cs(sw_cs_a), .sw_data_in(sw_data_in_a)
  );

  hpi_txn_sequencer #(
    .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .RECOVER_CYC(1), .RD_LAT(4)
  ) u_dut_b (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .busy(busy_b),
    .sw_address(sw_address_b), .sw_data_out(sw_data_out_b),
    .sw_r(sw_r_b), .sw_w(sw_w_b), .sw_cs(sw_cs_b), .sw_data_in(sw_data_in_b)
  );

  typedef struct {
    int          due;
    bit          rd;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];
  int vectors      = 0;
  int miscompares  = 0;
  int cyc          = 0;
  int resp_count_a = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge, and retire any response from DUT A.
  task automatic tick();
    exp_t e;
    @(posedge Clk);
    #1;
    cyc++;
    if (resp_valid_a === 1'b1) begin
      resp_count_a++;
      if (sb.size() == 0) begin
        check("resp_unexpected", 32'(resp_valid_a), 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_cycle", 32'(cyc), 32'(e.due));
        if (e.rd) check("resp_rdata", 32'(resp_rdata_a), 32'(e.rdata));
      end
    end
  endtask

  // One transaction on DUT A with the default timeline; returns in cycle 9 (IDLE).
  task automatic run_txn_a(input bit wr, input logic [1:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rdata, input logic [15:0] prev_dout);
    logic [15:0] exp_dout;
    exp_dout = wr ? wdata : prev_dout;
    check("accept_ready", 32'(req_ready_a), 32'd1);
    req_valid_a  = 1'b1;
    req_write_a  = wr;
    req_addr_a   = addr;
    req_wdata_a  = wdata;
    sw_data_in_a = 16'($urandom);
    sb.push_back('{due: cyc + 8, rd: !wr, rdata: rdata});
    tick();
    req_valid_a = 1'b0;
    req_wdata_a = 16'hDEAD;
    req_addr_a  = ~addr;
    for (int t = 1; t <= 9; t++) begin
      check("sw_cs", 32'(sw_cs_a), (t <= 6) ? 32'd0 : 32'd1);
      check("sw_r", 32'(sw_r_a), (!wr && t >= 2 && t <= 5) ? 32'd0 : 32'd1);
      check("sw_w", 32'(sw_w_a), (wr && t >= 2 && t <= 5) ? 32'd0 : 32'd1);
      check("sw_address", 32'(sw_address_a), 32'(addr));
      check("sw_data_out", 32'(sw_data_out_a), 32'(exp_dout));
      check("req_ready", 32'(req_ready_a), 32'(t == 9));
      check("busy", 32'(busy_a), 32'(t <= 8));
      check("resp_valid", 32'(resp_valid_a), 32'(t == 8));
      sw_data_in_a = (t == 7) ? rdata : 16'($urandom);
      if (t < 9) tick();
    end
  endtask

  initial begin
    int k;
    int hi;
    bit seen;
    bit armed;
    int acc_cyc[3];
    int resp_before;

    Reset = 1'b1;
    req_valid_a = 1'b0; req_write_a = 1'b0; req_addr_a = 2'd0; req_wdata_a = 16'd0;
    req_valid_b = 1'b0; req_write_b = 1'b0; req_addr_b = 2'd0; req_wdata_b = 16'd0;
    sw_data_in_a = 16'd0; sw_data_in_b = 16'd0;

    // Reset state
    tick();
    tick();
    check("rst_ready", 32'(req_ready_a), 32'd0);
    check("rst_cs", 32'(sw_cs_a), 32'd1);
    check("rst_r", 32'(sw_r_a), 32'd1);
    check("rst_w", 32'(sw_w_a), 32'd1);
    check("rst_resp_valid", 32'(resp_valid_a), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_address", 32'(sw_address_a), 32'd0);
    check("rst_data_out", 32'(sw_data_out_a), 32'd0);
    Reset = 1'b0;
    #1;
    check("post_rst_ready_a", 32'(req_ready_a), 32'd1);
    check("post_rst_ready_b", 32'(req_ready_b), 32'd1);

    // Write addr 2, then read addr 0 returning BEEF
    run_txn_a(1'b1, 2'd2, 16'h1234, 16'h0000, 16'h0000);
    run_txn_a(1'b0, 2'd0, 16'h0000, 16'hBEEF, 16'h1234);
    check("read_keeps_rdata", 32'(resp_rdata_a), 32'hBEEF);

    // Three back-to-back writes with req_valid held high
    k = 0; hi = 0; seen = 1'b0; armed = 1'b0;
    resp_before = resp_count_a;
    req_valid_a = 1'b1;
    req_write_a = 1'b1;
    begin
      int start;
      start = cyc;
      for (int n = 0; n < 30; n++) begin
        if (k < 3) begin
          req_addr_a  = 2'(k + 1);
          req_wdata_a = 16'hA000 + 16'(k);
        end
        if (!sw_cs_a) begin
          if (armed) check("cs_gap_ge2", 32'(hi >= 2), 32'd1);
          armed = 1'b0; hi = 0; seen = 1'b1;
        end else begin
          hi++;
          if (seen) armed = 1'b1;
        end
        if (req_valid_a && req_ready_a) begin
          acc_cyc[k] = cyc - start;
          sb.push_back('{due: cyc + 8, rd: 1'b0, rdata: 16'h0000});
          k++;
        end
        tick();
        if (k == 3) req_valid_a = 1'b0;
      end
    end
    check("b2b_accepts", 32'(k), 32'd3);
    check("b2b_acc0", 32'(acc_cyc[0]), 32'd0);
    check("b2b_acc1", 32'(acc_cyc[1]), 32'd9);
    check("b2b_acc2", 32'(acc_cyc[2]), 32'd18);
    check("b2b_resp_pulses", 32'(resp_count_a - resp_before), 32'd3);
    check("b2b_last_data", 32'(sw_data_out_a), 32'hA002);

    // Reset in cycle 3 of a write
    req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 2'd1; req_wdata_a = 16'h7777;
    sb.push_back('{due: cyc + 8, rd: 1'b0, rdata: 16'h0000});
    tick();
    req_valid_a = 1'b0;
    tick();
    tick();
    check("mid_w_low", 32'(sw_w_a), 32'd0);
    Reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready_a), 32'd0);
    sb.delete();
    tick();
    Reset = 1'b0;
    #1;
    check("mid_rst_w", 32'(sw_w_a), 32'd1);
    check("mid_rst_cs", 32'(sw_cs_a), 32'd1);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_addr", 32'(sw_address_a), 32'd0);
    check("mid_rst_dout", 32'(sw_data_out_a), 32'd0);
    check("mid_rst_ready_after", 32'(req_ready_a), 32'd1);
    resp_before = resp_count_a;
    for (int t = 0; t < 10; t++) begin
      check("mid_rst_no_resp", 32'(resp_valid_a), 32'd0);
      tick();
    end
    check("mid_rst_resp_count", 32'(resp_count_a - resp_before), 32'd0);
    run_txn_a(1'b0, 2'd3, 16'h0000, 16'h5A5A, 16'h0000);

    // Requests raised only while busy are not accepted
    req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 2'd1; req_wdata_a = 16'h1111;
    sb.push_back('{due: cyc + 8, rd: 1'b0, rdata: 16'h0000});
    tick();
    req_valid_a = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      if (t >= 2 && t <= 8) check("busy_req_ready", 32'(req_ready_a), 32'd0);
      if (t >= 9) begin
        check("idle_cs", 32'(sw_cs_a), 32'd1);
        check("idle_busy", 32'(busy_a), 32'd0);
      end
      req_valid_a = (t >= 2 && t <= 7);
      req_addr_a  = 2'd3;
      req_write_a = 1'b0;
      tick();
    end
    check("busy_req_addr_unchanged", 32'(sw_address_a), 32'd1);

    // Short phases with long read latency on DUT B
    check("b_accept_ready", 32'(req_ready_b), 32'd1);
    req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = 2'd2;
    sw_data_in_b = 16'($urandom);
    tick();
    req_valid_b = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      check("b_cs", 32'(sw_cs_b), (t <= 3) ? 32'd0 : 32'd1);
      check("b_r", 32'(sw_r_b), (t == 2) ? 32'd0 : 32'd1);
      check("b_w", 32'(sw_w_b), 32'd1);
      check("b_resp_valid", 32'(resp_valid_b), 32'(t == 7));
      check("b_busy", 32'(busy_b), 32'(t <= 7));
      check("b_ready", 32'(req_ready_b), 32'(t == 8));
      if (t == 7) check("b_rdata", 32'(resp_rdata_b), 32'hC3C3);
      sw_data_in_b = (t == 6) ? 16'hC3C3 : 16'($urandom);
      if (t < 8) tick();
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
